// File: rtl/filter_pkg.sv
// Shared definitions for the edge-preserving filter datapath: pixel width,
// default line length and the c1..c9 window order used by the adder pipeline.
package filter_pkg;

  localparam int PIX_W         = 8;
  localparam int DEF_IMG_WIDTH = 640;
  localparam int WIN_ROWS      = 3;
  localparam int WIN_COLS      = 3;

  // Tap order shared with the 9-input adder: row-major, top-left first.
  typedef enum logic [3:0] {
    W_C1 = 4'd0, W_C2 = 4'd1, W_C3 = 4'd2,
    W_C4 = 4'd3, W_C5 = 4'd4, W_C6 = 4'd5,
    W_C7 = 4'd6, W_C8 = 4'd7, W_C9 = 4'd8
  } win_idx_e;

  function automatic win_idx_e win_tap(input int row, input int col);
    return win_idx_e'(4'(row * WIN_COLS + col));
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line circular buffer: a single address per cycle, combinational read of
// the old contents and a write of the new value on the enabled clock edge.
module line_buffer #(
  parameter int DATA_W    = 8,
  parameter int IMG_WIDTH = 640,
  localparam int ADDR_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [IMG_WIDTH];

  // Read sees the value from before this edge's write, so a cascade can
  // forward the previous line while the new one lands.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two cascaded line buffers feed a shifting
// register window; win_valid flags windows fully inside the image.
module window_3x3_gen
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int DATA_W    = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] c1,
  output logic [DATA_W-1:0] c2,
  output logic [DATA_W-1:0] c3,
  output logic [DATA_W-1:0] c4,
  output logic [DATA_W-1:0] c5,
  output logic [DATA_W-1:0] c6,
  output logic [DATA_W-1:0] c7,
  output logic [DATA_W-1:0] c8,
  output logic [DATA_W-1:0] c9,
  output logic              win_valid
);

  localparam int            AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_COL = AW'(IMG_WIDTH - 1);

  logic [AW-1:0] col_cnt, col_eff, col_nxt;
  logic [1:0]    row_cnt, row_eff, row_nxt;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              lb_en;

  // [row][col], col 0 is the left (oldest) column.
  logic [WIN_ROWS-1:0][WIN_COLS-1:0][DATA_W-1:0] win_q;
  logic [WIN_ROWS-1:0][DATA_W-1:0]               col_in;
  logic [WIN_ROWS*WIN_COLS-1:0][DATA_W-1:0]      taps;

  // sof forces the current pixel to (0,0) regardless of counter state.
  always_comb begin
    col_eff = sof ? '0 : col_cnt;
    row_eff = sof ? '0 : row_cnt;
    col_nxt = col_eff + AW'(1);
    row_nxt = row_eff;
    if (col_eff == LAST_COL) begin
      col_nxt = '0;
      if (row_eff != 2'd2) row_nxt = row_eff + 2'd1;
    end
  end

  assign lb_en = pix_valid & ~rst;

  line_buffer #(.DATA_W(DATA_W), .IMG_WIDTH(IMG_WIDTH)) u_lb_a (
    .clk     (clk),
    .en      (lb_en),
    .addr    (col_eff),
    .wr_data (pix_in),
    .rd_data (a_rd)
  );

  line_buffer #(.DATA_W(DATA_W), .IMG_WIDTH(IMG_WIDTH)) u_lb_b (
    .clk     (clk),
    .en      (lb_en),
    .addr    (col_eff),
    .wr_data (a_rd),
    .rd_data (b_rd)
  );

  assign col_in[0] = b_rd;
  assign col_in[1] = a_rd;
  assign col_in[2] = pix_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      win_q     <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= pix_valid && (row_eff == 2'd2) && (col_eff >= AW'(2));
      if (pix_valid) begin
        col_cnt <= col_nxt;
        row_cnt <= row_nxt;
        for (int r = 0; r < WIN_ROWS; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= col_in[r];
        end
      end
    end
  end

  for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
    for (genvar c = 0; c < WIN_COLS; c++) begin : g_col
      assign taps[win_tap(r, c)] = win_q[r][c];
    end
  end

  assign c1 = taps[W_C1];
  assign c2 = taps[W_C2];
  assign c3 = taps[W_C3];
  assign c4 = taps[W_C4];
  assign c5 = taps[W_C5];
  assign c6 = taps[W_C6];
  assign c7 = taps[W_C7];
  assign c8 = taps[W_C8];
  assign c9 = taps[W_C9];

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Builds the 3x3 neighbourhood from a raster-order 8-bit pixel stream and presents the nine pixels to the 9-input adder pipeline that follows it in the edge-preserving filter datapath.
- Two line buffers hold the previous two image rows. A 3x3 register array shifts one column per accepted pixel.
- A `win_valid` flag marks windows that lie fully inside the image. There is no border padding.

Parameters:
- IMG_WIDTH, 640, pixels per line. Must be ≥ 3.
- DATA_W, 8, pixel width. Must match the adder inputs.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  DATA_W  input pixel, raster order
- pix_valid  in  1  pix_in is accepted this cycle
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0)
- c1..c9  out  DATA_W each  window: c1 c2 c3 = top row, c4 c5 c6 = middle row, c7 c8 c9 = bottom row; left to right within a row; c5 = centre; c9 = newest pixel
- win_valid  out  1  c1..c9 form a complete in-image window this cycle

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - c1..c9 = 0, win_valid = 0.
  - col_cnt = 0, row_cnt = 0.
  - Line-buffer contents are not reset; they are don't-care until rewritten.
- Accept: a pixel is accepted when pix_valid = 1. With pix_valid = 0 nothing moves: counters, window and buffers hold, and win_valid = 0.
- On an accepted pixel at column col:
  - Line buffer A reads address col, giving row r-1. Line buffer B reads address col, giving row r-2.
  - B[col] is written with A[col]'s old value. A[col] is written with pix_in.
  - Window shifts left: c1←c2←c3←B-out; c4←c5←c6←A-out; c7←c8←c9←pix_in.
  - Read-before-write on the same address within the cycle is required.
- Counters:
  - col_cnt increments per accepted pixel and wraps from IMG_WIDTH-1 to 0.
  - On wrap, row_cnt increments and saturates at 2. Only a "row ≥ 2" flag is needed downstream.
- sof:
  - When sof = 1 with pix_valid = 1, the pixel is treated as col 0, row 0.
  - The counter update on that cycle yields col_cnt = 1, row_cnt = 0, regardless of the prior state.
  - sof without pix_valid is ignored.
- win_valid is registered with the window. It equals 1 in the cycle after accepting a pixel whose (row ≥ 2) and (col ≥ 2), evaluated before the counter update.
- Latency: 1 cycle from an accepted pixel to its appearance at c9.
- Line-end behaviour: the window crosses the line boundary (c1/c4/c7 hold previous-line data at col 0 and 1). win_valid = 0 there, so the data is masked.
- Valid windows per frame: (IMG_WIDTH-2) × (H-2), where H = number of lines.
- Reset mid-frame: outputs clear next cycle. The next accepted pixel is treated as (0,0) even without sof.
- Short last line or missing sof: no error detection; counters run free.

Decomposition:
- Shared package `filter_pkg`: PIX_W = 8, default IMG_WIDTH, and the window index order c1..c9. The adder pipeline and this block use the same order.
- One sub-module, `line_buffer`: a DATA_W × IMG_WIDTH circular buffer with one read and one write port at the same address per cycle, read-old-data semantics, and an enable input.
- Instantiated twice, cascaded: A output feeds B input.
- Address width = clog2(IMG_WIDTH).

Test Plan:
- Ramp, IMG_WIDTH = 4, 4 lines, pix = row×16 + col, continuous pix_valid, sof on the first pixel:
  - First win_valid occurs the cycle after pixel 0x22 is accepted.
  - Window = c1..c9 = 00, 01, 02, 10, 11, 12, 20, 21, 22.
  - Exactly 4 windows in the frame; the last one is 11, 12, 13, 21, 22, 23, 31, 32, 33.
- Same stream with pix_valid toggling 1,0,1,0:
  - Identical window sequence.
  - win_valid never high in a cycle following pix_valid = 0.
  - Outputs hold their values during gaps.
- Line-boundary masking: with the ramp, after accepting pixels 0x30 and 0x31, win_valid = 0 although the window registers are non-zero.
- rst asserted for 1 cycle after pixel 0x21, then a new ramp streamed without sof:
  - c1..c9 = 0 and win_valid = 0 the cycle after rst.
  - First valid window again 00..22 after pixel (2,2) of the new stream.
- sof reasserted mid-frame (at old pixel 0x12) with a new ramp offset of 0x80: no win_valid until pixel 0xA2 is accepted, and that window's bottom row is 0xA0, 0xA1, 0xA2.
- Saturation: IMG_WIDTH = 640, 480 lines random data. Scoreboard compares every win_valid window against a frame model; total window count = 638 × 478 = 304964.
